// File: rtl/coh_bus_pkg.sv
// Shared types for the snoop-bus controller, the cache controllers and the bench.
package coh_bus_pkg;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BCAST = 3'd1,
        SNOOP = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam int CMD_W = 2;

    // Only a plain read may install the line shared; RDX/UPGR/WB leave the
    // requester as sole owner, so another cache's hit is not reported.
    function automatic logic shared_for(input bus_cmd_t cmd, input logic hit);
        return hit && (cmd == BUS_RD);
    endfunction

endpackage

// File: rtl/coh_bus_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import coh_bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Scan N positions starting at ptr; the first asserted request wins.
    always_comb begin : arb_scan
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/coh_bus_arbiter.sv
// Snoop-bus controller: round-robin grant, broadcast, snoop collection,
// single memory port sequencing for fills/writebacks, response to requester.
//
// state | meaning
// IDLE  | waiting for any req; winner context captured on the leaving edge
// BCAST | one cycle: bus_valid and gnt[src] high
// SNOOP | waiting for snoop_done from every cache except src
// MEM   | fill read on the memory port until mem_ready
// WB    | memory write of dirty snooper data (or requester data for BUS_WB)
// RESP  | one cycle: resp_valid[src] high with data and shared flag
module coh_bus_arbiter
    import coh_bus_pkg::*;
#(
    parameter int N_CACHES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CACHES-1:0]           req,
    input  logic [2*N_CACHES-1:0]         req_cmd,
    input  logic [ADDR_W*N_CACHES-1:0]    req_addr,
    input  logic [DATA_W*N_CACHES-1:0]    req_wdata,
    output logic [N_CACHES-1:0]           gnt,
    output logic                          bus_valid,
    output logic [1:0]                    bus_cmd,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [$clog2(N_CACHES)-1:0]   bus_src,
    input  logic [N_CACHES-1:0]           snoop_done,
    input  logic [N_CACHES-1:0]           snoop_hit,
    input  logic [N_CACHES-1:0]           snoop_dirty,
    input  logic [DATA_W*N_CACHES-1:0]    snoop_data,
    output logic                          mem_req,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic [N_CACHES-1:0]           resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_shared,
    output logic                          err_multi_dirty
);

    localparam int                 IDX_W    = $clog2(N_CACHES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_CACHES - 1);
    localparam logic [N_CACHES-1:0] ONE     = N_CACHES'(1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      src_q, src_d;
    bus_cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  hit_q, hit_d;
    logic [N_CACHES-1:0]   gnt_q, gnt_d;
    logic                  bus_valid_q, bus_valid_d;
    logic [N_CACHES-1:0]   resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     resp_data_q, resp_data_d;
    logic                  resp_shared_q, resp_shared_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_write_q, mem_write_d;
    logic                  err_q, err_d;

    logic [N_CACHES-1:0]   arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    bus_cmd_t              win_cmd;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_wdata;

    logic [N_CACHES-1:0]   src_oh;
    logic [N_CACHES-1:0]   hit_m;
    logic [N_CACHES-1:0]   dirty_m;
    logic                  all_done;
    logic                  multi_dirty;
    logic [DATA_W-1:0]     dirty_data;

    rr_arbiter #(
        .N   (N_CACHES)
    ) u_rr_arbiter (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Mux the winning cache's command, address and writeback data.
    always_comb begin
        win_cmd   = BUS_RD;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < N_CACHES; i++) begin
            if (arb_gnt[i]) begin
                win_cmd   = bus_cmd_t'(req_cmd[CMD_W*i +: CMD_W]);
                win_addr  = req_addr[ADDR_W*i +: ADDR_W];
                win_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Merge snoop responses from every cache other than the requester;
    // the lowest-index dirty snooper supplies the line.
    always_comb begin : snoop_merge
        logic dirty_found;
        src_oh         = '0;
        src_oh[src_q]  = 1'b1;
        hit_m          = snoop_hit & ~src_oh;
        dirty_m        = snoop_dirty & ~src_oh;
        all_done       = &(snoop_done | src_oh);
        multi_dirty    = |(dirty_m & (dirty_m - ONE));
        dirty_data     = '0;
        dirty_found    = 1'b0;
        for (int i = 0; i < N_CACHES; i++) begin
            if (!dirty_found && dirty_m[i]) begin
                dirty_data  = snoop_data[DATA_W*i +: DATA_W];
                dirty_found = 1'b1;
            end
        end
    end

    // Next state plus next output values; outputs are decided on the
    // transition so they line up with the state they belong to.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        src_d         = src_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        hit_d         = hit_q;
        gnt_d         = '0;
        bus_valid_d   = 1'b0;
        resp_valid_d  = '0;
        resp_data_d   = resp_data_q;
        resp_shared_d = 1'b0;
        mem_req_d     = mem_req_q;
        mem_write_d   = mem_write_q;
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    src_d       = arb_idx;
                    cmd_d       = win_cmd;
                    addr_d      = win_addr;
                    wdata_d     = win_wdata;
                    hit_d       = 1'b0;
                    ptr_d       = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
                    gnt_d       = arb_gnt;
                    bus_valid_d = 1'b1;
                    state_d     = BCAST;
                end
            end
            BCAST: begin
                if (cmd_q == BUS_WB) begin
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b1;
                    state_d     = WB;
                end else begin
                    state_d     = SNOOP;
                end
            end
            SNOOP: begin
                if (all_done) begin
                    hit_d = |hit_m;
                    if (multi_dirty) begin
                        err_d = 1'b1;
                    end
                    if (|dirty_m) begin
                        wdata_d     = dirty_data;
                        mem_req_d   = 1'b1;
                        mem_write_d = 1'b1;
                        state_d     = WB;
                    end else if (cmd_q == BUS_UPGR) begin
                        resp_valid_d  = src_oh;
                        resp_shared_d = shared_for(cmd_q, |hit_m);
                        state_d       = RESP;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_write_d = 1'b0;
                        state_d     = MEM;
                    end
                end
            end
            MEM: begin
                if (mem_ready) begin
                    resp_data_d   = mem_rdata;
                    mem_req_d     = 1'b0;
                    resp_valid_d  = src_oh;
                    resp_shared_d = shared_for(cmd_q, hit_q);
                    state_d       = RESP;
                end
            end
            WB: begin
                if (mem_ready) begin
                    resp_data_d   = wdata_q;
                    mem_req_d     = 1'b0;
                    mem_write_d   = 1'b0;
                    resp_valid_d  = src_oh;
                    resp_shared_d = shared_for(cmd_q, hit_q);
                    state_d       = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                mem_req_d   = 1'b0;
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, transaction context and all outputs register together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            src_q         <= '0;
            cmd_q         <= BUS_RD;
            addr_q        <= '0;
            wdata_q       <= '0;
            hit_q         <= 1'b0;
            gnt_q         <= '0;
            bus_valid_q   <= 1'b0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            resp_shared_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            src_q         <= src_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            hit_q         <= hit_d;
            gnt_q         <= gnt_d;
            bus_valid_q   <= bus_valid_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_shared_q <= resp_shared_d;
            mem_req_q     <= mem_req_d;
            mem_write_q   <= mem_write_d;
            err_q         <= err_d;
        end
    end

    assign gnt             = gnt_q;
    assign bus_valid       = bus_valid_q;
    assign bus_cmd         = cmd_q;
    assign bus_addr        = addr_q;
    assign bus_src         = src_q;
    assign mem_req         = mem_req_q;
    assign mem_write       = mem_write_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_shared     = resp_shared_q;
    assign err_multi_dirty = err_q;

endmodule
